multicycle_control: RTL and testbench

//  Multi-cycle control FSM that drives the datapath register-file/immediate block: generates read

---
 rtl/multicycle_control.sv | 193 +++++++++++++++++++
 tb/tb_multicycle_control.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multi-cycle control sequencer: walks each instruction through FETCH/DECODE/EXEC/MEM/WB,
// driving register-file addresses, PC/IR/ALU controls and a req/ready memory handshake.
module multicycle_control #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [15:0] instr,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        IorD,
    output logic        IRWrite,
    output logic        PCWrite,
    output logic [1:0]  PCSrc,
    output logic [1:0]  ALUSrcB,
    output logic [3:0]  ALUOp,
    output logic [2:0]  input_reg_readA_address,
    output logic [2:0]  input_reg_readB_address,
    output logic        input_reg_write,
    output logic [2:0]  input_reg_write_address,
    output logic        memToReg,
    output logic        fault
);

    localparam int unsigned TW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LIMIT = TW'(MEM_TIMEOUT);
    localparam logic [TW-1:0] TMO_LAST  = TW'(MEM_TIMEOUT - 1);

    localparam logic [2:0] OP_3R  = 3'd0;
    localparam logic [2:0] OP_2RI = 3'd1;
    localparam logic [2:0] OP_RI  = 3'd2;
    localparam logic [2:0] OP_L   = 3'd3;
    localparam logic [2:0] OP_UJ  = 3'd4;
    localparam logic [2:0] OP_LW  = 3'd5;
    localparam logic [2:0] OP_SW  = 3'd6;
    localparam logic [2:0] OP_BEQ = 3'd7;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    state_t         state_q, state_d;
    logic           active_q, fault_q, fault_d;
    logic [TW-1:0]  tmo_q, tmo_d;
    logic [2:0]     op_q, op_d, rd_q, rd_d, ra_q, ra_d, rb_q, rb_d;
    logic [3:0]     funct_q, funct_d;

    assign fault = fault_q;

    // Next-state and control decode; outputs stay low until the first edge after reset release.
    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        fault_d = fault_q;
        op_d    = op_q;
        rd_d    = rd_q;
        funct_d = funct_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        mem_req = 1'b0;
        mem_we  = 1'b0;
        IorD    = 1'b0;
        IRWrite = 1'b0;
        PCWrite = 1'b0;
        PCSrc   = 2'b00;
        ALUSrcB = 2'b00;
        ALUOp   = 4'b0000;
        input_reg_readA_address = ra_q;
        input_reg_readB_address = rb_q;
        input_reg_write         = 1'b0;
        input_reg_write_address = 3'd0;
        memToReg                = 1'b0;
        if (!active_q) begin
            state_d = S_FETCH;
            tmo_d   = '0;
        end else if (tmo_q == TMO_LIMIT) begin
            // Timed-out request: one quiet cycle with mem_req dropped, then refetch.
            state_d = S_FETCH;
            tmo_d   = '0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        IRWrite = 1'b1;
                        PCWrite = 1'b1;
                        tmo_d   = '0;
                        state_d = S_DECODE;
                    end else begin
                        tmo_d   = tmo_q + 1'b1;
                        fault_d = fault_q | (tmo_q == TMO_LAST);
                    end
                end
                S_DECODE: begin
                    input_reg_readA_address = instr[12:10];
                    input_reg_readB_address = instr[9:7];
                    ra_d    = instr[12:10];
                    rb_d    = instr[9:7];
                    op_d    = instr[2:0];
                    rd_d    = instr[15:13];
                    funct_d = instr[6:3];
                    state_d = S_EXEC;
                end
                S_EXEC: begin
                    case (op_q)
                        OP_3R: begin
                            ALUOp   = funct_q;
                            state_d = S_WB;
                        end
                        OP_RI: begin
                            ALUSrcB = 2'b10;
                            ALUOp   = funct_q;
                            state_d = S_WB;
                        end
                        OP_2RI, OP_L: begin
                            ALUSrcB = 2'b10;
                            state_d = S_WB;
                        end
                        OP_LW, OP_SW: begin
                            ALUSrcB = 2'b10;
                            state_d = S_MEM;
                        end
                        OP_BEQ: begin
                            ALUOp   = 4'b0001;
                            PCWrite = zero;
                            PCSrc   = 2'b01;
                            state_d = S_FETCH;
                        end
                        OP_UJ: begin
                            PCWrite = 1'b1;
                            PCSrc   = 2'b10;
                            input_reg_write         = 1'b1;
                            input_reg_write_address = rd_q;
                            state_d = S_FETCH;
                        end
                        default: state_d = S_FETCH;
                    endcase
                end
                S_MEM: begin
                    mem_req = 1'b1;
                    IorD    = 1'b1;
                    mem_we  = (op_q == OP_SW);
                    if (mem_ready) begin
                        tmo_d   = '0;
                        state_d = (op_q == OP_SW) ? S_FETCH : S_WB;
                    end else begin
                        tmo_d   = tmo_q + 1'b1;
                        fault_d = fault_q | (tmo_q == TMO_LAST);
                    end
                end
                S_WB: begin
                    input_reg_write         = 1'b1;
                    input_reg_write_address = rd_q;
                    memToReg                = (op_q == OP_LW);
                    state_d                 = S_FETCH;
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

    // State, latched instruction fields, timeout counter and sticky fault.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= S_FETCH;
            active_q <= 1'b0;
            tmo_q    <= '0;
            fault_q  <= 1'b0;
            op_q     <= 3'd0;
            rd_q     <= 3'd0;
            funct_q  <= 4'd0;
            ra_q     <= 3'd0;
            rb_q     <= 3'd0;
        end else begin
            state_q  <= state_d;
            active_q <= 1'b1;
            tmo_q    <= tmo_d;
            fault_q  <= fault_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            funct_q  <= funct_d;
            ra_q     <= ra_d;
            rb_q     <= rb_d;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: an instruction-level model builds the expected per-cycle
// control vector from the opcode rules and memory wait counts; every cycle is compared.
module tb_multicycle_control;

    typedef struct packed {
        logic       mem_req, mem_we, iord, irw, pcw;
        logic [1:0] pcsrc, alusrcb;
        logic [3:0] aluop;
        logic [2:0] ra, rb;
        logic       wr;
        logic [2:0] wa;
        logic       m2r, fault;
    } out_t;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [15:0] instr_i = 16'h0000;
    logic        zero_i = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_req, mem_we, IorD, IRWrite, PCWrite;
    logic [1:0]  PCSrc, ALUSrcB;
    logic [3:0]  ALUOp;
    logic [2:0]  ra_o, rb_o, wa_o;
    logic        wr_o, m2r_o, fault_o;
    out_t        act_now, act;

    int checks = 0;
    int errors = 0;
    int cyc_n = 0;
    int wr_count = 0;
    int memreq_cnt = 0;
    int memwe_cnt = 0;
    string tag = "reset";

    logic       fault_m = 1'b0;
    logic [2:0] prev_a = 3'd0;
    logic [2:0] prev_b = 3'd0;
    bit         to;

    multicycle_control #(.MEM_TIMEOUT(16)) dut (
        .CLK(CLK), .RST_N(RST_N), .instr(instr_i), .zero(zero_i), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .IorD(IorD), .IRWrite(IRWrite), .PCWrite(PCWrite),
        .PCSrc(PCSrc), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .input_reg_readA_address(ra_o), .input_reg_readB_address(rb_o),
        .input_reg_write(wr_o), .input_reg_write_address(wa_o),
        .memToReg(m2r_o), .fault(fault_o)
    );

    always #5 CLK = ~CLK;

    assign act_now = {mem_req, mem_we, IorD, IRWrite, PCWrite, PCSrc, ALUSrcB, ALUOp,
                      ra_o, rb_o, wr_o, wa_o, m2r_o, fault_o};

    function automatic out_t idle();
        out_t e;
        e = '0;
        e.ra = prev_a;
        e.rb = prev_b;
        e.fault = fault_m;
        return e;
    endfunction

    // One clock: drive mem_ready at the falling edge, compare the whole control vector just after.
    task automatic cyc(input logic rdy, input out_t e);
        @(negedge CLK);
        mem_ready = rdy;
        #1;
        cyc_n++;
        act = act_now;
        checks++;
        if (act !== e) begin
            errors++;
            $display("FAIL cycle %0d [%s]: got %h expected %h", cyc_n, tag, act, e);
        end
        if (act.wr) wr_count++;
        if (act.mem_req && act.iord) memreq_cnt++;
        if (act.mem_we) memwe_cnt++;
    endtask

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST_N = 1'b0;
        mem_ready = 1'b0;
        #1;
        chk("reset_outputs_zero", int'(act_now == out_t'('0)), 1);
        @(negedge CLK);
        chk("reset_held_zero", int'(act_now == out_t'('0)), 1);
        RST_N = 1'b1;
        fault_m = 1'b0;
        prev_a = 3'd0;
        prev_b = 3'd0;
    endtask

    // Memory wait: up to 16 busy cycles, then the request is abandoned with a quiet cycle.
    task automatic wait_phase(input int waits, input bit data, input bit st, output bit tmo);
        out_t e;
        tmo = 1'b0;
        for (int n = 0; n <= waits; n++) begin
            if (n == 16) begin
                fault_m = 1'b1;
                e = idle();
                cyc(1'b1, e);
                tmo = 1'b1;
                return;
            end
            if (n == waits) return;
            e = idle();
            e.mem_req = 1'b1;
            e.iord = data;
            e.mem_we = st;
            cyc(1'b0, e);
        end
    endtask

    task automatic fetch_phase(input int waits, output bit tmo);
        out_t e;
        tag = "fetch";
        wait_phase(waits, 1'b0, 1'b0, tmo);
        if (!tmo) begin
            e = idle();
            e.mem_req = 1'b1;
            e.irw = 1'b1;
            e.pcw = 1'b1;
            cyc(1'b1, e);
        end
    endtask

    task automatic decode_phase();
        tag = "decode";
        prev_a = instr_i[12:10];
        prev_b = instr_i[9:7];
        cyc(1'b1, idle());
    endtask

    task automatic exec_phase();
        out_t e;
        logic [2:0] op;
        tag = "exec";
        op = instr_i[2:0];
        e = idle();
        case (op)
            3'd0: e.aluop = instr_i[6:3];
            3'd2: begin e.alusrcb = 2'b10; e.aluop = instr_i[6:3]; end
            3'd1, 3'd3, 3'd5, 3'd6: e.alusrcb = 2'b10;
            3'd7: begin e.aluop = 4'd1; e.pcw = zero_i; e.pcsrc = 2'b01; end
            default: begin e.pcw = 1'b1; e.pcsrc = 2'b10; e.wr = 1'b1; e.wa = instr_i[15:13]; end
        endcase
        cyc(1'b1, e);
    endtask

    task automatic mem_phase(input int waits, output bit tmo);
        out_t e;
        bit st;
        tag = "mem";
        st = (instr_i[2:0] == 3'd6);
        wait_phase(waits, 1'b1, st, tmo);
        if (!tmo) begin
            e = idle();
            e.mem_req = 1'b1;
            e.iord = 1'b1;
            e.mem_we = st;
            cyc(1'b1, e);
        end
    endtask

    task automatic wb_phase();
        out_t e;
        tag = "wb";
        e = idle();
        e.wr = 1'b1;
        e.wa = instr_i[15:13];
        e.m2r = (instr_i[2:0] == 3'd5);
        cyc(1'b1, e);
    endtask

    task automatic run_instr(input logic [15:0] ins, input logic z, input int fw, input int mw);
        bit tmo;
        instr_i = ins;
        zero_i = z;
        fetch_phase(fw, tmo);
        if (tmo) return;
        decode_phase();
        exec_phase();
        if (ins[2:0] == 3'd5 || ins[2:0] == 3'd6) begin
            mem_phase(mw, tmo);
            if (tmo) return;
        end
        if (ins[2:0] != 3'd4 && ins[2:0] != 3'd6 && ins[2:0] != 3'd7) wb_phase();
    endtask

    initial begin
        do_reset();

        // 3R rd=2 rs1=2 rs2=1 funct=3
        instr_i = 16'h4898;
        fetch_phase(0, to);
        decode_phase();
        chk("t2_readA", int'(act.ra), 2);
        chk("t2_readB", int'(act.rb), 1);
        exec_phase();
        chk("t2_aluop", int'(act.aluop), 3);
        wb_phase();
        chk("t2_write", int'(act.wr), 1);
        chk("t2_waddr", int'(act.wa), 2);
        chk("t2_memToReg", int'(act.m2r), 0);

        // LW rd=4 with three memory wait cycles
        instr_i = 16'h8405;
        fetch_phase(2, to);
        decode_phase();
        exec_phase();
        memreq_cnt = 0;
        mem_phase(3, to);
        chk("t3_memreq_cycles", memreq_cnt, 4);
        wb_phase();
        chk("t3_waddr", int'(act.wa), 4);
        chk("t3_memToReg", int'(act.m2r), 1);

        // SW: store strobe, never a register write
        wr_count = 0;
        memwe_cnt = 0;
        run_instr(16'h6A86, 1'b0, 1, 2);
        chk("t4_no_write", wr_count, 0);
        chk("t4_mem_we_cycles", memwe_cnt, 3);

        // BEQ taken / not taken
        wr_count = 0;
        instr_i = 16'h0507;
        zero_i = 1'b1;
        fetch_phase(0, to);
        decode_phase();
        exec_phase();
        chk("t5_taken_pcwrite", int'(act.pcw), 1);
        chk("t5_taken_pcsrc", int'(act.pcsrc), 1);
        zero_i = 1'b0;
        fetch_phase(1, to);
        decode_phase();
        exec_phase();
        chk("t5_nottaken_pcwrite", int'(act.pcw), 0);
        chk("t5_no_write", wr_count, 0);

        // UJ link, RI, 2RI, L with rd=0
        run_instr(16'hE004, 1'b0, 0, 0);
        run_instr(16'h744A, 1'b0, 2, 0);
        run_instr(16'h2C49, 1'b1, 0, 0);
        run_instr(16'h0003, 1'b0, 1, 0);

        // Fetch timeout, then fault must persist through later instructions
        instr_i = 16'h4898;
        fetch_phase(20, to);
        chk("t6_timeout_taken", int'(to), 1);
        chk("t6_mem_req_dropped", int'(act.mem_req), 0);
        chk("t6_fault", int'(act.fault), 1);
        run_instr(16'h4898, 1'b0, 1, 0);
        run_instr(16'h8405, 1'b0, 0, 16);
        chk("t6_fault_sticky", int'(fault_o), 1);

        // Reset in the middle of a memory wait
        instr_i = 16'h8405;
        fetch_phase(0, to);
        decode_phase();
        exec_phase();
        tag = "mem";
        for (int k = 0; k < 2; k++) begin
            act = idle();
            act.mem_req = 1'b1;
            act.iord = 1'b1;
            cyc(1'b0, act);
        end
        do_reset();
        run_instr(16'h4898, 1'b0, 0, 0);
        chk("t1_fault_cleared", int'(fault_o), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
